axis_byte_packer: RTL and testbench

AXIS_BYTE_PACKER -- requirements
Module: axis_byte_packer

---
 rtl/axis_byte_packer_if.sv | 24 ++
 rtl/axis_byte_packer.sv | 113 +++++++++++
 tb/tb_axis_byte_packer.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_byte_packer_if.sv
// Bundles the byte-in / word-out AXI-Stream signals of the byte packer.
// The slave modport is the packer's view; the master modport is its environment.
interface axis_byte_packer_if;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic        frame_split;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tstrb, m_tlast, m_tvalid, frame_split
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tstrb, m_tlast, m_tvalid, frame_split
  );
endinterface

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXI-Stream into little-endian 32-bit words with lane strobes,
// forcing a frame boundary every MAX_WORDS words (one BRAM row).
module axis_byte_packer #(
  parameter int MAX_WORDS = 36
) (
  input  logic        s00_axis_aclk,
  input  logic        s00_axis_aresetn,
  input  logic [7:0]  s00_axis_tdata,
  input  logic        s00_axis_tvalid,
  output logic        s00_axis_tready,
  input  logic        s00_axis_tlast,
  output logic [31:0] m00_axis_tdata,
  output logic [3:0]  m00_axis_tstrb,
  output logic        m00_axis_tlast,
  output logic        m00_axis_tvalid,
  input  logic        m00_axis_tready,
  output logic        frame_split
);

  localparam int WCW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [WCW-1:0] LAST_IDX = WCW'(MAX_WORDS - 1);

  logic [31:0]    acc_data;
  logic [3:0]     acc_strb;
  logic [1:0]     byte_cnt;
  logic           acc_last;
  logic           acc_full;
  logic [WCW-1:0] word_cnt;

  logic        in_fire;
  logic        slot_free;
  logic        word_done;
  logic        load_acc;
  logic        load_new;
  logic        load_any;
  logic        acc_full_nxt;
  logic [31:0] merged_data;
  logic [3:0]  merged_strb;
  logic [31:0] load_data;
  logic [3:0]  load_strb;
  logic        load_in_last;
  logic        at_limit;

  // A parked word and a freshly completed word never coincide: tready is low while parked.
  always_comb begin
    in_fire      = s00_axis_tvalid && s00_axis_tready;
    slot_free    = !m00_axis_tvalid || m00_axis_tready;
    merged_data  = acc_data | ({24'd0, s00_axis_tdata} << {byte_cnt, 3'b000});
    merged_strb  = acc_strb | (4'b0001 << byte_cnt);
    word_done    = in_fire && ((byte_cnt == 2'd3) || s00_axis_tlast);
    load_acc     = acc_full && slot_free;
    load_new     = word_done && slot_free;
    load_any     = load_acc || load_new;
    acc_full_nxt = !load_any && (acc_full || word_done);
    load_data    = load_acc ? acc_data : merged_data;
    load_strb    = load_acc ? acc_strb : merged_strb;
    load_in_last = load_acc ? acc_last : s00_axis_tlast;
    at_limit     = (word_cnt == LAST_IDX);
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      m00_axis_tdata  <= '0;
      m00_axis_tstrb  <= '0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      frame_split     <= 1'b0;
      word_cnt        <= '0;
    end else begin
      frame_split <= 1'b0;
      if (load_any) begin
        m00_axis_tdata  <= load_data;
        m00_axis_tstrb  <= load_strb;
        m00_axis_tlast  <= load_in_last || at_limit;
        m00_axis_tvalid <= 1'b1;
        frame_split     <= at_limit && !load_in_last;
        word_cnt        <= (load_in_last || at_limit) ? '0 : word_cnt + 1'b1;
      end else if (m00_axis_tready) begin
        m00_axis_tvalid <= 1'b0;
      end
    end
  end

  // The accumulator doubles as a one-word skid buffer when the output slot is busy.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      acc_data        <= '0;
      acc_strb        <= '0;
      byte_cnt        <= '0;
      acc_last        <= 1'b0;
      acc_full        <= 1'b0;
      s00_axis_tready <= 1'b0;
    end else begin
      s00_axis_tready <= !acc_full_nxt;
      acc_full        <= acc_full_nxt;
      if (load_any) begin
        acc_data <= '0;
        acc_strb <= '0;
        byte_cnt <= '0;
        acc_last <= 1'b0;
      end else if (word_done) begin
        acc_data <= merged_data;
        acc_strb <= merged_strb;
        acc_last <= s00_axis_tlast;
      end else if (in_fire) begin
        acc_data <= merged_data;
        acc_strb <= merged_strb;
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Self-checking bench for axis_byte_packer: vector table, corner-case sequences
// and a byte-stream reference model feeding an expected-word queue.
module tb_axis_byte_packer;

  localparam int MAX_WORDS = 36;

  typedef struct {
    int          n;
    logic [7:0]  first;
    logic [7:0]  step;
    int          exp_words;
    logic [31:0] exp_last_data;
    logic [3:0]  exp_last_strb;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic        split;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   ready_mode = 1;

  axis_byte_packer_if bus();

  axis_byte_packer #(.MAX_WORDS(MAX_WORDS)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tdata   (bus.s_tdata),
    .s00_axis_tvalid  (bus.s_tvalid),
    .s00_axis_tready  (bus.s_tready),
    .s00_axis_tlast   (bus.s_tlast),
    .m00_axis_tdata   (bus.m_tdata),
    .m00_axis_tstrb   (bus.m_tstrb),
    .m00_axis_tlast   (bus.m_tlast),
    .m00_axis_tvalid  (bus.m_tvalid),
    .m00_axis_tready  (bus.m_tready),
    .frame_split      (bus.frame_split)
  );

  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;

  exp_t        exp_q[$];
  logic [31:0] m_acc_data = '0;
  logic [3:0]  m_acc_strb = '0;
  int          m_acc_cnt = 0;
  int          m_frame_words = 0;
  int          exp_splits = 0;
  int          exp_words = 0;

  int          out_words = 0;
  int          out_lasts = 0;
  int          split_seen = 0;
  int          in_bytes = 0;
  logic        tready_drop = 1'b0;
  logic [31:0] last_data = '0;
  logic [3:0]  last_strb = '0;
  logic        last_flag = 1'b0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [3:0]  prev_strb = '0;
  logic        prev_last = 1'b0;

  vec_t vecs[7];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic fail_event(input string name);
    check_count++;
    $display("[TB] FAIL %s: got timeout/unexpected event, expected none", name);
  endtask

  task automatic model_accept(input logic [7:0] b, input logic last);
    exp_t e;
    m_acc_data = m_acc_data | (32'(b) << (8 * m_acc_cnt));
    m_acc_strb[m_acc_cnt] = 1'b1;
    m_acc_cnt++;
    if (m_acc_cnt == 4 || last) begin
      m_frame_words++;
      e.data  = m_acc_data;
      e.strb  = m_acc_strb;
      e.last  = last;
      e.split = 1'b0;
      if (m_frame_words == MAX_WORDS) begin
        e.last  = 1'b1;
        e.split = !last;
      end
      if (e.last) m_frame_words = 0;
      if (e.split) exp_splits++;
      exp_q.push_back(e);
      exp_words++;
      m_acc_data = '0;
      m_acc_strb = '0;
      m_acc_cnt  = 0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_acc_data    = '0;
    m_acc_strb    = '0;
    m_acc_cnt     = 0;
    m_frame_words = 0;
  endtask

  task automatic clear_stats();
    out_words   = 0;
    out_lasts   = 0;
    split_seen  = 0;
    in_bytes    = 0;
    exp_splits  = 0;
    exp_words   = 0;
    tready_drop = 1'b0;
  endtask

  // Downstream ready pattern: 0 = stalled, 1 = always ready, 2 = random.
  initial begin
    bus.m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.m_tready = 1'b0;
        1:       bus.m_tready = 1'b1;
        default: bus.m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Inputs only move just after posedge, so a negedge sample predicts the next edge.
  always @(negedge clk) begin
    exp_t e;
    logic ok;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_output("hold_valid", 32'(bus.m_tvalid), 32'd1);
        check_output("hold_data", bus.m_tdata, prev_data);
        check_output("hold_strb_last", {27'd0, bus.m_tstrb, bus.m_tlast}, {27'd0, prev_strb, prev_last});
      end
      if (bus.frame_split) begin
        split_seen++;
        ok = bus.m_tvalid && bus.m_tlast && (exp_q.size() > 0) && exp_q[0].split;
        check_output("frame_split_word", 32'(ok), 32'd1);
      end
      if (bus.m_tvalid && bus.m_tready) begin
        out_words++;
        last_data = bus.m_tdata;
        last_strb = bus.m_tstrb;
        last_flag = bus.m_tlast;
        if (bus.m_tlast) out_lasts++;
        if (exp_q.size() == 0) begin
          fail_event("unexpected_word");
        end else begin
          e = exp_q.pop_front();
          check_output("word_data", bus.m_tdata, e.data);
          check_output("word_strb_last", {27'd0, bus.m_tstrb, bus.m_tlast}, {27'd0, e.strb, e.last});
        end
      end
      if (bus.s_tvalid && bus.s_tready) begin
        in_bytes++;
        model_accept(bus.s_tdata, bus.s_tlast);
      end
      if (bus.s_tvalid && !bus.s_tready) tready_drop = 1'b1;
      prev_stall = bus.m_tvalid && !bus.m_tready;
      prev_data  = bus.m_tdata;
      prev_strb  = bus.m_tstrb;
      prev_last  = bus.m_tlast;
    end
  end

  task automatic apply_stimulus(input logic [7:0] b, input logic last);
    int waited;
    waited = 0;
    bus.s_tdata  = b;
    bus.s_tlast  = last;
    bus.s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.s_tready) begin
        @(posedge clk);
        #1;
        break;
      end
      waited++;
      if (waited > 2000) begin
        fail_event("s_tready_timeout");
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_mode = 1;
    while ((exp_q.size() != 0 || bus.m_tvalid) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) fail_event("drain_timeout");
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_m_tvalid"}, 32'(bus.m_tvalid), 32'd0);
    check_output({tag, "_m_tdata"}, bus.m_tdata, 32'd0);
    check_output({tag, "_strb_last_split"}, {26'd0, bus.m_tstrb, bus.m_tlast, bus.frame_split}, 32'd0);
    check_output({tag, "_s_tready"}, 32'(bus.s_tready), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8, 8'h01, 8'h01, 2, 32'h08070605, 4'hF};
    vecs[1] = '{3, 8'hAA, 8'h11, 1, 32'h00CCBBAA, 4'h7};
    vecs[2] = '{1, 8'h5A, 8'h00, 1, 32'h0000005A, 4'h1};
    vecs[3] = '{2, 8'h10, 8'h01, 1, 32'h00001110, 4'h3};
    vecs[4] = '{4, 8'h20, 8'h01, 1, 32'h23222120, 4'hF};
    vecs[5] = '{5, 8'h30, 8'h01, 2, 32'h00000034, 4'h1};
    vecs[6] = '{7, 8'h40, 8'h01, 2, 32'h00464544, 4'h7};

    bus.s_tdata  = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_held");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check_output("tready_after_reset", 32'(bus.s_tready), 32'd1);
    repeat (2) @(posedge clk);
    #1;

    for (int v = 0; v < 7; v++) begin
      clear_stats();
      for (int i = 0; i < vecs[v].n; i++)
        apply_stimulus(vecs[v].first + 8'(i) * vecs[v].step, i == vecs[v].n - 1);
      bus.s_tvalid = 1'b0;
      check_output($sformatf("v%0d_latency_valid", v), 32'(bus.m_tvalid), 32'd1);
      check_output($sformatf("v%0d_latency_data", v), bus.m_tdata, vecs[v].exp_last_data);
      drain();
      check_output($sformatf("v%0d_words", v), 32'(out_words), 32'(vecs[v].exp_words));
      check_output($sformatf("v%0d_last_data", v), last_data, vecs[v].exp_last_data);
      check_output($sformatf("v%0d_last_strb_flag", v), {27'd0, last_strb, last_flag}, {27'd0, vecs[v].exp_last_strb, 1'b1});
      check_output($sformatf("v%0d_tready_steady", v), 32'(tready_drop), 32'd0);
    end

    // Backpressure: second word parks in the accumulator and input stalls after byte 8.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1 clear_stats();
    fork
      begin
        for (int i = 0; i < 12; i++) apply_stimulus(8'(i + 1), i == 11);
        bus.s_tvalid = 1'b0;
      end
      begin
        int n;
        n = 0;
        while (in_bytes < 8 && n < 200) begin
          @(posedge clk);
          n++;
        end
        repeat (3) @(posedge clk);
        #2;
        check_output("bp_bytes_taken", 32'(in_bytes), 32'd8);
        check_output("bp_s_tready_low", 32'(bus.s_tready), 32'd0);
        check_output("bp_m_tvalid", 32'(bus.m_tvalid), 32'd1);
        check_output("bp_first_word", bus.m_tdata, 32'h04030201);
        ready_mode = 1;
      end
    join
    drain();
    check_output("bp_words", 32'(out_words), 32'd3);
    check_output("bp_last_data", last_data, 32'h0C0B0A09);

    // 168 bytes = 42 words: forced boundary after word 36, real tlast on word 42.
    clear_stats();
    for (int i = 0; i < 168; i++) apply_stimulus(8'(i), i == 167);
    bus.s_tvalid = 1'b0;
    drain();
    check_output("split_words", 32'(out_words), 32'd42);
    check_output("split_lasts", 32'(out_lasts), 32'd2);
    check_output("split_pulses", 32'(split_seen), 32'd1);

    // Reset mid-frame with one word pending and two bytes accumulated.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1 clear_stats();
    for (int i = 0; i < 6; i++) apply_stimulus(8'hE0 + 8'(i), 1'b0);
    bus.s_tvalid = 1'b0;
    check_output("mid_pending_valid", 32'(bus.m_tvalid), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("mid_reset");
    ready_mode = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 clear_stats();
    for (int i = 0; i < 4; i++) apply_stimulus(8'h11 + 8'(i), i == 3);
    bus.s_tvalid = 1'b0;
    drain();
    check_output("post_reset_words", 32'(out_words), 32'd1);
    check_output("post_reset_data", last_data, 32'h14131211);
    check_output("post_reset_strb_flag", {27'd0, last_strb, last_flag}, {27'd0, 4'hF, 1'b1});

    // Random source gaps and sink stalls over 1000 bytes.
    ready_mode = 2;
    clear_stats();
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      apply_stimulus(8'($urandom), (i == 999) || ($urandom_range(0, 99) == 0));
    end
    bus.s_tvalid = 1'b0;
    drain();
    check_output("rand_bytes", 32'(in_bytes), 32'd1000);
    check_output("rand_words", 32'(out_words), 32'(exp_words));
    check_output("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    check_output("rand_no_partial", 32'(m_acc_cnt), 32'd0);
    check_output("rand_split_pulses", 32'(split_seen), 32'(exp_splits));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
